aggregator_seq: RTL and testbench

- Sequential, resource-shared rule aggregator. One g→Q1.15 converter and one 16x16 multiplier are time-multiplexed over the active rules of the 3x3 grid.
- Produces S_w = Σ w_ij and S_wg = Σ (w_ij·g_ij), bit-identical to the combinational aggregator.
- Sits between the rule-weight stage and the defuzzifier divider. Uses valid/ready on input and output; area is traded for latency.

---
 rtl/aggregator_pkg.sv | 33 +++
 rtl/aggregator_mac.sv | 24 ++
 rtl/aggregator_seq.sv | 117 +++++++++++
 tb/tb_aggregator_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aggregator_pkg.sv
// Shared constants, state encoding, rule-order tables and the percent-to-Q1.15
// converter used by both the sequential and combinational rule aggregators.
package aggregator_pkg;

  localparam int ACC_W    = 20;
  localparam int Q15_MAX  = 32767;
  localparam int HALF_LSB = 1 << 14;
  localparam int PCT_DIV  = 100;

  localparam int N_M0 = 4;
  localparam int N_M1 = 9;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  // Grid index (r*3+c) of the rule handled at each step; entry 0 is step 0.
  localparam logic [3:0][3:0] ORDER_M0 = {4'd8, 4'd6, 4'd2, 4'd0};
  localparam logic [8:0][3:0] ORDER_M1 = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4,
                                          4'd3, 4'd2, 4'd1, 4'd0};

  // Round-half-up percent to Q1.15; anything above 100 % pins at full scale.
  function automatic logic [15:0] g2q15_pct(input logic [7:0] g);
    logic [23:0] scaled;
    logic [23:0] q;
    scaled = 24'(g) * 24'(Q15_MAX) + 24'(PCT_DIV / 2);
    q      = scaled / 24'(PCT_DIV);
    return (q > 24'(Q15_MAX)) ? 16'(Q15_MAX) : q[15:0];
  endfunction

endpackage

// File: rtl/aggregator_mac.sv
// Single-rule term: converts the singleton to Q1.15, multiplies by the rule
// weight and rounds back to a saturated Q1.15 product.
module aggregator_mac
  import aggregator_pkg::*;
(
  input  logic [15:0] w,
  input  logic [7:0]  g,
  output logic [15:0] p
);

  logic [15:0] gq;
  logic [31:0] prod;
  logic [31:0] rnd;
  logic [16:0] shifted;

  always_comb begin
    gq      = g2q15_pct(g);
    prod    = 32'(w) * 32'(gq);
    rnd     = prod + 32'(HALF_LSB);
    shifted = 17'(rnd >> 15);
    p       = (shifted > 17'(Q15_MAX)) ? 16'(Q15_MAX) : shifted[15:0];
  end

endmodule

// File: rtl/aggregator_seq.sv
// Sequential rule aggregator: one MAC walks the active rules of a latched job,
// then presents saturated S_w / S_wg until the consumer takes them.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and data is held while valid is high.
module aggregator_seq
  import aggregator_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         reg_mode,
  input  logic [143:0] w_flat,
  input  logic [71:0]  g_flat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  S_w,
  output logic [15:0]  S_wg,
  output logic         busy,
  output logic [3:0]   rule_idx
);

  state_e            state_q, state_d;
  logic [8:0][15:0]  w_q;
  logic [8:0][7:0]   g_q;
  logic              mode_q;
  logic [3:0]        step_q;
  logic [ACC_W-1:0]  acc_w_q, acc_wg_q;
  logic [ACC_W-1:0]  acc_w_nx, acc_wg_nx;
  logic [3:0]        rule_cur;
  logic              last_step;
  logic [15:0]       p_k;

  function automatic logic [15:0] sat_q15(input logic [ACC_W-1:0] a);
    return (a > ACC_W'(Q15_MAX)) ? 16'(Q15_MAX) : a[15:0];
  endfunction

  always_comb begin
    rule_cur  = mode_q ? ORDER_M1[step_q] : ORDER_M0[step_q[1:0]];
    last_step = (step_q == 4'(mode_q ? N_M1 - 1 : N_M0 - 1));
    acc_w_nx  = acc_w_q  + ACC_W'(w_q[rule_cur]);
    acc_wg_nx = acc_wg_q + ACC_W'(p_k);
  end

  aggregator_mac u_mac (
    .w (w_q[rule_cur]),
    .g (g_q[rule_cur]),
    .p (p_k)
  );

  // Next state; clr overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ACC;
      ACC:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    rule_idx  = (state_q == ACC) ? rule_cur : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      g_q      <= '0;
      mode_q   <= 1'b0;
      step_q   <= '0;
      acc_w_q  <= '0;
      acc_wg_q <= '0;
      S_w      <= '0;
      S_wg     <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        step_q   <= '0;
        acc_w_q  <= '0;
        acc_wg_q <= '0;
        S_w      <= '0;
        S_wg     <= '0;
      end else begin
        case (state_q)
          IDLE: if (in_valid) begin
            w_q      <= w_flat;
            g_q      <= g_flat;
            mode_q   <= reg_mode;
            step_q   <= '0;
            acc_w_q  <= '0;
            acc_wg_q <= '0;
          end
          ACC: begin
            acc_w_q  <= acc_w_nx;
            acc_wg_q <= acc_wg_nx;
            step_q   <= step_q + 4'd1;
            // Results are frozen here so they stay stable through DONE.
            if (last_step) begin
              S_w  <= sat_q15(acc_w_nx);
              S_wg <= sat_q15(acc_wg_nx);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aggregator_seq.sv
// Bench for aggregator_seq: directed vector table, multi-cycle corner
// sequences, and randomized back-to-back jobs against an arithmetic model.
module tb_aggregator_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic         reg_mode;
  logic [143:0] w_flat;
  logic [71:0]  g_flat;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  S_w;
  logic [15:0]  S_wg;
  logic         busy;
  logic [3:0]   rule_idx;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int rules_q[$];

  aggregator_seq dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .reg_mode(reg_mode), .w_flat(w_flat), .g_flat(g_flat),
    .out_valid(out_valid), .out_ready(out_ready), .S_w(S_w), .S_wg(S_wg),
    .busy(busy), .rule_idx(rule_idx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Reference: sum active rules straight from the arithmetic definition.
  function automatic logic [31:0] ref_model(input logic mode, input logic [143:0] w,
                                            input logic [71:0] g);
    longint sw = 0, swg = 0;
    for (int r = 0; r < 9; r++) begin
      bit corner = (r == 0) || (r == 2) || (r == 6) || (r == 8);
      if (mode || corner) begin
        longint wv = longint'(w[r*16 +: 16]);
        longint gv = longint'(g[r*8 +: 8]);
        longint gq = (gv * 32767 + 50) / 100;
        longint p;
        if (gq > 32767) gq = 32767;
        p = (wv * gq + 16384) / 32768;
        if (p > 32767) p = 32767;
        sw  += wv;
        swg += p;
      end
    end
    if (sw > 32767) sw = 32767;
    if (swg > 32767) swg = 32767;
    return {sw[15:0], swg[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_job(input logic mode, input logic [143:0] w, input logic [71:0] g,
                          output bit ok);
    int n = 0;
    @(negedge clk);
    reg_mode = mode;
    w_flat   = w;
    g_flat   = g;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      note_fail("accept_timeout");
      ok = 1'b0;
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Counts negedges from accept until out_valid, logging rule_idx each cycle.
  task automatic wait_done(output int lat);
    rules_q.delete();
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      rules_q.push_back(int'(rule_idx));
      @(negedge clk);
      lat++;
    end
    if (!out_valid) note_fail("done_timeout");
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic         mode;
    logic [143:0] w;
    logic [71:0]  g;
    logic [15:0]  exp_sw;
    logic [15:0]  exp_swg;
    int           exp_lat;
  } vec_t;

  vec_t vecs[4];
  int order_m0[4] = '{0, 2, 6, 8};

  initial begin
    bit ok;
    int lat;
    int bad;
    logic [31:0] exp;
    logic [143:0] w_r;
    logic [71:0]  g_r;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; reg_mode = 1'b0;
    w_flat = '0; g_flat = '0; out_ready = 1'b0;

    for (int r = 0; r < 9; r++) begin
      vecs[0].w[r*16 +: 16] = 16'(1000 * (r + 1));
      vecs[0].g[r*8 +: 8]   = 8'(10 * (r + 1));
      vecs[1].w[r*16 +: 16] = 16'd32767;
      vecs[1].g[r*8 +: 8]   = 8'd0;
      vecs[2].w[r*16 +: 16] = 16'd32767;
      vecs[2].g[r*8 +: 8]   = 8'd100;
      vecs[3].w[r*16 +: 16] = (r == 0 || r == 2 || r == 6 || r == 8) ? 16'd0 :
                              ((r % 2) == 1 ? 16'd1000 : 16'd5000);
      vecs[3].g[r*8 +: 8]   = 8'd50;
    end
    vecs[0].mode = 1'b0; vecs[0].exp_sw = 16'd20000; vecs[0].exp_swg = 16'd14000; vecs[0].exp_lat = 4;
    vecs[1].mode = 1'b1; vecs[1].exp_sw = 16'd32767; vecs[1].exp_swg = 16'd0;     vecs[1].exp_lat = 9;
    vecs[2].mode = 1'b1; vecs[2].exp_sw = 16'd32767; vecs[2].exp_swg = 16'd32767; vecs[2].exp_lat = 9;
    vecs[3].mode = 1'b0; vecs[3].exp_sw = 16'd0;     vecs[3].exp_swg = 16'd0;     vecs[3].exp_lat = 4;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_S_w", 32'(S_w), 32'd0);
    check("idle_S_wg", 32'(S_wg), 32'd0);
    check("idle_rule_idx", 32'(rule_idx), 32'd0);

    // Table-driven jobs
    for (int i = 0; i < 4; i++) begin
      send_job(vecs[i].mode, vecs[i].w, vecs[i].g, ok);
      if (ok) begin
        wait_done(lat);
        check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        check($sformatf("vec%0d_S_w", i), 32'(S_w), 32'(vecs[i].exp_sw));
        check($sformatf("vec%0d_S_wg", i), 32'(S_wg), 32'(vecs[i].exp_swg));
        check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
        check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd0);
        for (int k = 0; k < vecs[i].exp_lat && k < rules_q.size(); k++)
          check($sformatf("vec%0d_rule%0d", i, k), 32'(rules_q[k]),
                vecs[i].mode ? 32'(k) : 32'(order_m0[k]));
        take_result();
        check($sformatf("vec%0d_release", i), 32'(out_valid), 32'd0);
      end
    end

    // Back-pressure with input bus changing during ACC
    for (int r = 0; r < 9; r++) begin
      w_r[r*16 +: 16] = 16'($urandom_range(0, 32767));
      g_r[r*8 +: 8]   = 8'($urandom_range(0, 120));
    end
    exp = ref_model(1'b1, w_r, g_r);
    send_job(1'b1, w_r, g_r, ok);
    w_flat = ~w_r;
    g_flat = ~g_r;
    reg_mode = 1'b0;
    if (ok) begin
      wait_done(lat);
      for (int k = 0; k < 6; k++) begin
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_result", {S_w, S_wg}, exp);
        @(negedge clk);
      end
      take_result();
      check("bp_idle_in_ready", 32'(in_ready), 32'd1);
      check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    end

    // clr at ACC step 3
    send_job(1'b1, vecs[2].w, vecs[2].g, ok);
    if (ok) begin
      repeat (4) @(negedge clk);
      check("clr_rule_at_step3", 32'(rule_idx), 32'd3);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_in_ready", 32'(in_ready), 32'd1);
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_S_w", 32'(S_w), 32'd0);
      bad = 0;
      for (int k = 0; k < 12; k++) begin
        if (out_valid) bad++;
        @(negedge clk);
      end
      check("clr_no_valid", 32'(bad), 32'd0);
    end

    // Asynchronous reset mid-ACC, then a clean job
    send_job(1'b1, vecs[2].w, vecs[2].g, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rule_idx", 32'(rule_idx), 32'd0);
      check("arst_outputs", {S_w, S_wg}, 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
    end
    send_job(vecs[0].mode, vecs[0].w, vecs[0].g, ok);
    if (ok) begin
      wait_done(lat);
      check("after_rst_result", {S_w, S_wg}, {16'd20000, 16'd14000});
      take_result();
    end

    // Random back-to-back jobs with output stalls
    fork
      begin : driver
        for (int j = 0; j < 200; j++) begin
          logic m;
          m = 1'($urandom_range(0, 1));
          for (int r = 0; r < 9; r++) begin
            w_r[r*16 +: 16] = 16'($urandom_range(0, 32767));
            g_r[r*8 +: 8]   = 8'($urandom_range(0, 120));
          end
          send_job(m, w_r, g_r, ok);
          if (ok) exp_q.push_back(ref_model(m, w_r, g_r));
        end
      end
      begin : consumer
        int got = 0;
        int cyc = 0;
        while (got < 200 && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) note_fail("rand_unexpected_result");
            else check($sformatf("rand_job%0d", got), {S_w, S_wg}, exp_q.pop_front());
            got++;
          end
        end
        if (got < 200) note_fail("rand_results_timeout");
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
